// File: rtl/cordic_sincos_if.sv
// cordic_sincos_if
//   Groups the start/busy/valid handshake, the angle request and the
//   sine/cosine results of cordic_sincos into one bundle.
//
//   Signals:
//     angle_i  unsigned fraction of a full turn (2^WIDTH = 2*pi)
//     start_i  request, sampled only while busy_o is low
//     sin_o    signed Q2.(WIDTH-2) sine result
//     cos_o    signed Q2.(WIDTH-2) cosine result
//     busy_o   high while the micro-rotations run
//     valid_o  high while sin_o/cos_o hold a completed result
//
//   Modports:
//     master   requester side (drives angle_i/start_i)
//     slave    CORDIC engine side (drives the results and status)
interface cordic_sincos_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]        angle_i;
  logic                    start_i;
  logic signed [WIDTH-1:0] sin_o;
  logic signed [WIDTH-1:0] cos_o;
  logic                    busy_o;
  logic                    valid_o;

  modport master (
    output angle_i, start_i,
    input  sin_o, cos_o, busy_o, valid_o
  );

  modport slave (
    input  angle_i, start_i,
    output sin_o, cos_o, busy_o, valid_o
  );
endinterface

// File: rtl/cordic_sincos.sv
// cordic_sincos
//   Iterative rotation-mode CORDIC producing sine and cosine of a
//   full-circle angle. The two top angle bits select a quadrant; the
//   remaining first-quadrant angle is rotated ITERATIONS times starting
//   from (K, 0), then the quadrant mapping and saturation are applied
//   while the result is registered. Results hold until the next start.
//
//   Ports:
//     clk_i    clock, rising edge
//     reset_i  asynchronous reset, active low
//     bus      cordic_sincos_if.slave (angle_i, start_i, sin_o, cos_o,
//              busy_o, valid_o)
//
//   Parameters:
//     WIDTH       angle/result width, 8..32
//     ITERATIONS  number of micro-rotations, 4..min(WIDTH-2, 30)
//
//   Optional build macro:
//     CORDIC_UNROLL2_EN  two chained micro-rotations per ROTATE cycle;
//                        results are bit-identical to the default build.
module cordic_sincos #(
  parameter int WIDTH      = 32,
  parameter int ITERATIONS = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  cordic_sincos_if.slave   bus
);

  // Two guard bits keep the CORDIC gain (~1.647) and the negated quadrant
  // mappings from wrapping before saturation.
  localparam int WX = WIDTH + 2;
  localparam logic [5:0] ITER = 6'(ITERATIONS);
  localparam logic signed [WX-1:0] K_INIT =
    WX'(longint'(0.6072529350 * (2.0 ** (WIDTH - 2))));

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  state_t                  r_state;
  logic [5:0]              r_counter;
  logic [1:0]              r_quadrant;
  logic signed [WX-1:0]    r_x;
  logic signed [WX-1:0]    r_y;
  logic signed [WX-1:0]    r_z;
  logic signed [WIDTH-1:0] r_sin;
  logic signed [WIDTH-1:0] r_cos;
  logic                    r_busy;
  logic                    r_valid;

  logic [3*WX-1:0]         w_stage1;
  logic signed [WX-1:0]    w_x1;
  logic signed [WX-1:0]    w_y1;
  logic signed [WX-1:0]    w_z1;
  logic signed [WX-1:0]    w_xNext;
  logic signed [WX-1:0]    w_yNext;
  logic signed [WX-1:0]    w_zNext;
  logic [5:0]              w_step;
  logic signed [WX-1:0]    w_cosMap;
  logic signed [WX-1:0]    w_sinMap;

  // atan(2^-i) / (2*pi) in 32-bit turn units, rescaled to WIDTH bits.
  function automatic logic signed [WX-1:0] atanTurn(input logic [5:0] idx);
    logic signed [31:0] full;
    case (idx)
      6'd0:    full = 32'sh20000000;
      6'd1:    full = 32'sh12E4051E;
      6'd2:    full = 32'sh09FB385B;
      6'd3:    full = 32'sh051111D4;
      6'd4:    full = 32'sh028B0D43;
      6'd5:    full = 32'sh0145D7E1;
      6'd6:    full = 32'sh00A2F61E;
      6'd7:    full = 32'sh00517C55;
      6'd8:    full = 32'sh0028BE53;
      6'd9:    full = 32'sh00145F2F;
      6'd10:   full = 32'sh000A2F98;
      6'd11:   full = 32'sh000517CC;
      6'd12:   full = 32'sh00028BE6;
      6'd13:   full = 32'sh000145F3;
      6'd14:   full = 32'sh0000A2FA;
      6'd15:   full = 32'sh0000517D;
      6'd16:   full = 32'sh000028BE;
      6'd17:   full = 32'sh0000145F;
      6'd18:   full = 32'sh00000A30;
      6'd19:   full = 32'sh00000518;
      6'd20:   full = 32'sh0000028C;
      6'd21:   full = 32'sh00000146;
      6'd22:   full = 32'sh000000A3;
      6'd23:   full = 32'sh00000051;
      6'd24:   full = 32'sh00000029;
      6'd25:   full = 32'sh00000014;
      6'd26:   full = 32'sh0000000A;
      6'd27:   full = 32'sh00000005;
      6'd28:   full = 32'sh00000003;
      6'd29:   full = 32'sh00000001;
      default: full = 32'sh00000000;
    endcase
    return WX'(full >>> (32 - WIDTH));
  endfunction

  // One micro-rotation; the direction drives the residual angle z to zero.
  function automatic logic [3*WX-1:0] microRotate(
    input logic signed [WX-1:0] x,
    input logic signed [WX-1:0] y,
    input logic signed [WX-1:0] z,
    input logic [5:0]           idx
  );
    logic signed [WX-1:0] xs;
    logic signed [WX-1:0] ys;
    logic signed [WX-1:0] xn;
    logic signed [WX-1:0] yn;
    logic signed [WX-1:0] zn;
    xs = x >>> idx;
    ys = y >>> idx;
    if (z[WX-1]) begin
      xn = x + ys;
      yn = y - xs;
      zn = z + atanTurn(idx);
    end else begin
      xn = x - ys;
      yn = y + xs;
      zn = z - atanTurn(idx);
    end
    return {xn, yn, zn};
  endfunction

  // The top three bits agree exactly when the value fits in WIDTH bits.
  function automatic logic [WIDTH-1:0] saturate(input logic signed [WX-1:0] v);
    if (v[WX-1:WIDTH-1] == {3{v[WX-1]}})
      return v[WIDTH-1:0];
    else if (v[WX-1])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign w_stage1 = microRotate(r_x, r_y, r_z, r_counter);
  assign w_x1     = w_stage1[3*WX-1 -: WX];
  assign w_y1     = w_stage1[2*WX-1 -: WX];
  assign w_z1     = w_stage1[WX-1:0];

`ifdef CORDIC_UNROLL2_EN
  logic [5:0]           w_idx2;
  logic [3*WX-1:0]      w_stage2;
  logic                 w_useTwo;

  // Second rotation chained on the first; skipped on the last cycle of an
  // odd iteration count so the total matches the single-step build.
  assign w_idx2   = r_counter + 6'd1;
  assign w_stage2 = microRotate(w_x1, w_y1, w_z1, w_idx2);
  assign w_useTwo = (w_idx2 < ITER);
  assign w_xNext  = w_useTwo ? w_stage2[3*WX-1 -: WX] : w_x1;
  assign w_yNext  = w_useTwo ? w_stage2[2*WX-1 -: WX] : w_y1;
  assign w_zNext  = w_useTwo ? w_stage2[WX-1:0]       : w_z1;
  assign w_step   = w_useTwo ? 6'd2 : 6'd1;
`else
  assign w_xNext = w_x1;
  assign w_yNext = w_y1;
  assign w_zNext = w_z1;
  assign w_step  = 6'd1;
`endif

  // Unfold the first-quadrant result into the quadrant of the request.
  always_comb begin
    w_cosMap = r_x;
    w_sinMap = r_y;
    case (r_quadrant)
      2'd1: begin
        w_cosMap = -r_y;
        w_sinMap = r_x;
      end
      2'd2: begin
        w_cosMap = -r_x;
        w_sinMap = -r_y;
      end
      2'd3: begin
        w_cosMap = r_y;
        w_sinMap = -r_x;
      end
      default: ;
    endcase
  end

  // Control FSM and datapath registers. ROTATE spends its final cycle
  // (counter == ITERATIONS) loading the mapped outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state    <= IDLE;
      r_counter  <= '0;
      r_quadrant <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_sin      <= '0;
      r_cos      <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start_i) begin
            r_state    <= ROTATE;
            r_quadrant <= bus.angle_i[WIDTH-1:WIDTH-2];
            r_z        <= {4'b0000, bus.angle_i[WIDTH-3:0]};
            r_x        <= K_INIT;
            r_y        <= '0;
            r_counter  <= '0;
            r_busy     <= 1'b1;
            r_valid    <= 1'b0;
          end
        end
        ROTATE: begin
          if (r_counter < ITER) begin
            r_x       <= w_xNext;
            r_y       <= w_yNext;
            r_z       <= w_zNext;
            r_counter <= r_counter + w_step;
          end else begin
            r_cos   <= saturate(w_cosMap);
            r_sin   <= saturate(w_sinMap);
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sin_o   = r_sin;
  assign bus.cos_o   = r_cos;
  assign bus.busy_o  = r_busy;
  assign bus.valid_o = r_valid;

endmodule

// File: doc/cordic_sincos.md
Name: cordic_sincos

Overview:
- Parametrised successor to the single-result iterative CORDIC.
- Computes sine and cosine together for a full-circle angle of configurable width and iteration count, with quadrant folding.
- Uses the same start/busy/valid handshake; results are held until the next start.
- Sits between the control FSM and the datapath consumers, and is driven directly by the file-driven bench flow.

Parameters:
- WIDTH, 32: angle and result width in bits. Legal range 8..32.
- ITERATIONS, 16: number of CORDIC micro-rotations. Legal range 4..min(WIDTH-2, 30).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- angle_i  in  WIDTH  unsigned fraction of a full turn; 0 = 0 rad, 2^WIDTH maps to 2π.
- start_i  in  1  request; sampled only when busy_o=0.
- sin_o  out  WIDTH  signed Q2.(WIDTH-2) sine; 1.0 = 2^(WIDTH-2).
- cos_o  out  WIDTH  signed Q2.(WIDTH-2) cosine.
- busy_o  out  1  high while rotating.
- valid_o  out  1  high while sin_o/cos_o hold a completed result.

Behaviour:
- Reset (reset_i=0, asynchronous): state IDLE; sin_o=0, cos_o=0, busy_o=0, valid_o=0; iteration counter=0.
- Reset asserted mid-operation aborts immediately, and no valid_o follows.
- States: IDLE, ROTATE, DONE.
- IDLE/DONE + start_i=1 → ROTATE on the next edge, with these registrations:
  - angle_i latched.
  - q = angle_i[WIDTH-1:WIDTH-2].
  - z0 = angle_i with its top 2 bits cleared.
  - x0 = K = round(0.6072529350 * 2^(WIDTH-2)).
  - y0 = 0; counter=0.
  - busy_o=1; valid_o=0.
- ROTATE, per cycle i = counter:
  - d = sign(z): z≥0 → d=+1.
  - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan_i.
  - counter++.
  - After i = ITERATIONS-1 → DONE.
- atan_i: constant table of 30 entries, atan(2^-i)/(2π) in 32-bit turn units, arithmetic-right-shifted by 32-WIDTH.
- Internal x/y/z are WIDTH+2 bits signed (guard against overflow); shifts are arithmetic.
- Entering DONE registers the outputs with quadrant mapping (c=x, s=y, saturated to the WIDTH range):
  - q=0: cos=c, sin=s.
  - q=1: cos=-s, sin=c.
  - q=2: cos=-c, sin=-s.
  - q=3: cos=s, sin=-c.
- On entering DONE: busy_o=0, valid_o=1.
- Latency: start sampled at edge 0 → valid_o=1 after edge ITERATIONS+1.
- busy_o is high for exactly ITERATIONS+1 cycles.
- DONE holds outputs and valid_o indefinitely until a new start_i is accepted. valid_o then falls on that same accepting edge; outputs keep their old value until the new result loads.
- start_i while busy_o=1: ignored, with no queueing and no effect on the running computation.
- angle_i changes during ROTATE have no effect (latched at start).
- start_i held high continuously: a new computation begins on each edge where busy_o=0, i.e. back-to-back with a 1-cycle DONE.
- Accuracy: |error| ≤ 2^(WIDTH-2-ITERATIONS+2) LSB per output.

Optional Feature:
- Macro: CORDIC_UNROLL2_EN.
- Defined: two micro-rotations per ROTATE cycle (i and i+1 chained combinationally).
  - ROTATE lasts ceil(ITERATIONS/2) cycles.
  - Latency ceil(ITERATIONS/2)+1; busy_o length matches.
  - Odd ITERATIONS: the final cycle performs one rotation.
  - Results are bit-identical to the non-unrolled build.
- Undefined: one rotation per cycle as above.

Test Plan (WIDTH=32, ITERATIONS=16, tolerance ±0x10000):
- angle_i=0x00000000, start pulse:
  - valid_o rises 17 cycles after start sampled.
  - cos_o≈0x40000000, sin_o≈0x00000000.
  - busy_o high exactly 17 cycles.
- angle_i=0x20000000 (45°) → cos_o≈sin_o≈0x2D413CCD.
- angle_i=0x40000000 → cos_o≈0, sin_o≈0x40000000.
- angle_i=0xC0000000 → cos_o≈0, sin_o≈0xC0000000.
- angle_i=0x80000000 → cos_o≈0xC0000000, sin_o≈0.
- Start accepted with angle_i=0x20000000; 5 cycles later pulse start_i with angle_i=0x40000000 → second start ignored; result matches 45°; valid_o holds until the next accepted start, then falls on that edge.
- Start a computation; drop reset_i to 0 at cycle 8, release 2 cycles later:
  - All outputs are 0 immediately on assertion.
  - No valid_o appears afterwards.
  - A new start completes normally.
- Rebuild with CORDIC_UNROLL2_EN and rerun the cases above → valid_o 9 cycles after start; outputs bit-identical to the default build.
